clmul_seq: RTL

- Multi-cycle carry-less (GF(2) polynomial) multiplier sequencer for W-bit operands.
- Time-shares one external 8x8 carry-less multiply core (15-bit product) using a schoolbook limb schedule.
- Accumulates the shifted partial products by XOR into a (2W-1)-bit result.
- Sits between a valid/ready request source (hash/CRC/GCM-style datapath) and the shared core; owns the core's operand inputs while busy.

---
 rtl/clmul_pkg.sv | 30 +++
 rtl/clmul_limb_acc.sv | 66 ++++++
 rtl/clmul_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clmul_pkg.sv
// Shared types and constants for the clmul_seq carry-less multiplier sequencer.
// Also provides clmul_ref, a behavioural GF(2) product used as a golden model.
package clmul_pkg;

    localparam int LIMB_W   = 8;
    localparam int CORE_Y_W = 15;
    localparam int IDX_W    = 4;   // holds i+j, at most 14
    localparam int CNT_W    = 3;   // holds a limb index, at most 7
    localparam int MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [2*MAX_W-2:0] clmul_ref(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b);
        logic [2*MAX_W-2:0] y;
        y = '0;
        for (int i = 0; i < MAX_W; i++) begin
            for (int j = 0; j < MAX_W; j++) begin
                y[i+j] = y[i+j] ^ (a[i] & b[j]);
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/clmul_limb_acc.sv
// XOR accumulator for shifted 15-bit limb products of clmul_seq.
// With CLMUL_SEQ_CORE_REG_EN defined, the product/shift pair is registered first.
module clmul_limb_acc
    import clmul_pkg::*;
#(
    parameter  int NLIMB = 4,
    localparam int RW    = 2*LIMB_W*NLIMB - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                en,
    input  logic [CORE_Y_W-1:0] prod,
    input  logic [IDX_W-1:0]    idx,
    output logic [RW-1:0]       acc
);

    logic [CORE_Y_W-1:0] p_d;
    logic [IDX_W-1:0]    idx_d;
    logic                v_d;
    logic [RW-1:0]       term;

`ifdef CLMUL_SEQ_CORE_REG_EN
    logic [CORE_Y_W-1:0] p_q;
    logic [IDX_W-1:0]    idx_q;
    logic                v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            idx_q <= '0;
            v_q   <= 1'b0;
        end else begin
            p_q   <= prod;
            idx_q <= idx;
            v_q   <= en;
        end
    end

    assign p_d   = p_q;
    assign idx_d = idx_q;
    assign v_d   = v_q;
`else
    assign p_d   = prod;
    assign idx_d = idx;
    assign v_d   = en;
`endif

    // Largest shift is 8*(2*NLIMB-2) = RW-15, so the product always fits.
    always_comb begin
        term                 = '0;
        term[CORE_Y_W-1:0]   = p_d;
        term                 = term << (LIMB_W * idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (v_d) begin
            acc <= acc ^ term;
        end
    end

endmodule

// File: rtl/clmul_seq.sv
// Multi-cycle W-bit carry-less multiplier time-sharing an external 8x8 core.
// Define CLMUL_SEQ_CORE_REG_EN to register core_y before accumulation (adds DRAIN).
module clmul_seq
    import clmul_pkg::*;
#(
    parameter  int NLIMB = 4,
    localparam int W     = LIMB_W*NLIMB,
    localparam int RW    = 2*W - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RW-1:0]       out_y,
    output logic                busy,
    output logic [LIMB_W-1:0]   core_a,
    output logic [LIMB_W-1:0]   core_b,
    input  logic [CORE_Y_W-1:0] core_y,
    output state_t              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds its payload stable until that edge.

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [CNT_W-1:0] i;
    logic [CNT_W-1:0] j;
    logic             accept;
    logic [RW-1:0]    acc;

    function automatic logic [LIMB_W-1:0] limb(input logic [W-1:0] v,
                                               input logic [CNT_W-1:0] k);
        return v[LIMB_W*k +: LIMB_W];
    endfunction

    assign accept    = (state == IDLE) && in_valid;
    assign out_y     = acc;
    assign dbg_state = state;

    clmul_limb_acc #(.NLIMB(NLIMB)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (state == RUN),
        .prod  (core_y),
        .idx   ({1'b0, i} + {1'b0, j}),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            core_a    <= '0;
            core_b    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        i        <= '0;
                        j        <= '0;
                        core_a   <= in_a[LIMB_W-1:0];
                        core_b   <= in_b[LIMB_W-1:0];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // core_a/core_b are preloaded with the next pair so each
                    // RUN cycle presents exactly the (i, j) limbs it accumulates.
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i      <= '0;
                            core_a <= '0;
                            core_b <= '0;
`ifdef CLMUL_SEQ_CORE_REG_EN
                            state  <= DRAIN;
`else
                            state     <= DONE;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            i      <= i + 3'd1;
                            core_a <= limb(a_q, i + 3'd1);
                            core_b <= limb(b_q, '0);
                        end
                    end else begin
                        j      <= j + 3'd1;
                        core_b <= limb(b_q, j + 3'd1);
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
